trap_controller: RTL and testbench

- Interrupt/trap sequencer directly downstream of the CSR file.
- Consumes the CSR file's timer-compare flag (comp), 4-bit enable mask (mie) and saved return address (mepc), plus an external IRQ pin and decoded ecall/mret strobes.
- Decides when to take a trap at an instruction boundary, pulses the CSR file's interrupt input so it captures the PC, and drives the PC-redirect path of the RV32IC datapath.

---
 rtl/trap_controller_pkg.sv | 27 ++
 rtl/trap_controller_irq_sync.sv | 27 ++
 rtl/trap_controller.sv | 121 ++++++++++++
 tb/tb_trap_controller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/trap_controller_pkg.sv
// Shared definitions for the trap sequencer: FSM encodings, trap cause codes,
// and the mie bit positions that the CSR file also uses.
package trap_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ENTER   = 2'd1,
      ST_HANDLER = 2'd2,
      ST_RETURN  = 2'd3
   } trap_state_t;

   localparam logic [31:0] CAUSE_ECALL = 32'h0000_000B;
   localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
   localparam logic [31:0] CAUSE_SW    = 32'h8000_0003;
   localparam logic [31:0] CAUSE_TMR   = 32'h8000_0007;

   localparam int MIE_GLB = 3;
   localparam int MIE_EXT = 2;
   localparam int MIE_SW  = 1;
   localparam int MIE_TMR = 0;

   // Handler address: base + 4*code, wrapping modulo 2^32.
   function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [3:0] code);
      return base + {26'd0, code, 2'b00};
   endfunction

endpackage

// File: rtl/trap_controller_irq_sync.sv
// Metastability synchronizer for the external IRQ pin, followed by a
// rising-edge detector on the synchronized level.
module irq_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic ext_irq,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   prev_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_reg <= '0;
         prev_reg <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], ext_irq};
         prev_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/trap_controller.sv
// Trap sequencer: picks the highest-priority eligible source at an instruction
// boundary, pulses the CSR capture and PC redirect, and handles MRET return.
module trap_controller
   import trap_controller_pkg::*;
#(
   parameter logic [31:0] VEC_BASE    = 32'h0000_0100,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        comp,
   input  logic [3:0]  mie,
   input  logic [31:0] mepc,
   input  logic        ext_irq,
   input  logic        sw_irq,
   input  logic        ecall,
   input  logic        mret,
   input  logic        instr_valid,
   output logic        interrupt,
   output logic        pc_load,
   output logic [31:0] new_pc,
   output logic [31:0] mcause,
   output logic        in_handler
);

   trap_state_t state_reg, state_next;
   logic        interrupt_reg, interrupt_next;
   logic        pc_load_reg, pc_load_next;
   logic [31:0] new_pc_reg, new_pc_next;
   logic [31:0] mcause_reg, mcause_next;
   logic        in_handler_reg, in_handler_next;
   logic        ext_pend_reg, ext_pend_next;

   logic        ext_rise;
   logic        ext_ok, sw_ok, tmr_ok, trap_any;
   logic [31:0] cause_sel;

   irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
      .clk     (clk),
      .rst     (rst),
      .ext_irq (ext_irq),
      .rise    (ext_rise)
   );

   assign ext_ok   = ext_pend_reg & mie[MIE_EXT] & mie[MIE_GLB];
   assign sw_ok    = sw_irq & mie[MIE_SW] & mie[MIE_GLB];
   assign tmr_ok   = comp & mie[MIE_TMR] & mie[MIE_GLB];
   assign trap_any = ecall | ext_ok | sw_ok | tmr_ok;

   always_comb begin
      cause_sel = CAUSE_TMR;
      if (ecall)       cause_sel = CAUSE_ECALL;
      else if (ext_ok) cause_sel = CAUSE_EXT;
      else if (sw_ok)  cause_sel = CAUSE_SW;
   end

   always_comb begin
      state_next      = state_reg;
      interrupt_next  = 1'b0;
      pc_load_next    = 1'b0;
      new_pc_next     = new_pc_reg;
      mcause_next     = mcause_reg;
      in_handler_next = in_handler_reg;
      ext_pend_next   = ext_pend_reg;
      case (state_reg)
         ST_IDLE: begin
            if (instr_valid && trap_any) begin
               state_next      = ST_ENTER;
               mcause_next     = cause_sel;
               interrupt_next  = 1'b1;
               pc_load_next    = 1'b1;
               new_pc_next     = vec_addr(VEC_BASE, cause_sel[3:0]);
               in_handler_next = 1'b1;
            end
         end
         ST_ENTER: begin
            state_next = ST_HANDLER;
            if (mcause_reg == CAUSE_EXT) ext_pend_next = 1'b0;
         end
         ST_HANDLER: begin
            if (mret && instr_valid) begin
               state_next      = ST_RETURN;
               pc_load_next    = 1'b1;
               new_pc_next     = mepc;
               in_handler_next = 1'b0;
            end
         end
         ST_RETURN: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
      // A fresh edge always wins over the clear so it is never lost.
      if (ext_rise) ext_pend_next = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= ST_IDLE;
         interrupt_reg  <= 1'b0;
         pc_load_reg    <= 1'b0;
         new_pc_reg     <= 32'd0;
         mcause_reg     <= 32'd0;
         in_handler_reg <= 1'b0;
         ext_pend_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         interrupt_reg  <= interrupt_next;
         pc_load_reg    <= pc_load_next;
         new_pc_reg     <= new_pc_next;
         mcause_reg     <= mcause_next;
         in_handler_reg <= in_handler_next;
         ext_pend_reg   <= ext_pend_next;
      end
   end

   assign interrupt  = interrupt_reg;
   assign pc_load    = pc_load_reg;
   assign new_pc     = new_pc_reg;
   assign mcause     = mcause_reg;
   assign in_handler = in_handler_reg;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: reset, timer trap/return, priority,
// global masking, no-nesting with timer retake, and reset during trap entry.
module tb_trap_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        comp;
   logic [3:0]  mie;
   logic [31:0] mepc;
   logic        ext_irq, sw_irq, ecall, mret, instr_valid;
   logic        interrupt, pc_load, in_handler;
   logic [31:0] new_pc, mcause;

   int vectors     = 0;
   int miscompares = 0;

   trap_controller #(.VEC_BASE(32'h0000_0100), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .comp        (comp),
      .mie         (mie),
      .mepc        (mepc),
      .ext_irq     (ext_irq),
      .sw_irq      (sw_irq),
      .ecall       (ecall),
      .mret        (mret),
      .instr_valid (instr_valid),
      .interrupt   (interrupt),
      .pc_load     (pc_load),
      .new_pc      (new_pc),
      .mcause      (mcause),
      .in_handler  (in_handler)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; comp = 1'b1; mie = 4'hF; mepc = 32'h1234_5678; ext_irq = 1'b1;
      sw_irq = 1'b1; ecall = 1'b1; mret = 1'b1; instr_valid = 1'b1;
      tick(); tick(); tick();
      vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL rst_interrupt got %b exp 0", interrupt); end
      vectors++; if (pc_load !== 1'b0) begin miscompares++; $display("FAIL rst_pc_load got %b exp 0", pc_load); end
      vectors++; if (new_pc !== 32'd0) begin miscompares++; $display("FAIL rst_new_pc got %h exp 0", new_pc); end
      vectors++; if (mcause !== 32'd0) begin miscompares++; $display("FAIL rst_mcause got %h exp 0", mcause); end
      vectors++; if (in_handler !== 1'b0) begin miscompares++; $display("FAIL rst_in_handler got %b exp 0", in_handler); end
      comp = 1'b0; mie = 4'h0; ext_irq = 1'b0; sw_irq = 1'b0; ecall = 1'b0; mret = 1'b0; instr_valid = 1'b1;
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         vectors++;
         if (interrupt !== 1'b0 || pc_load !== 1'b0 || in_handler !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_quiet cyc %0d got int=%b pcl=%b inh=%b exp 0/0/0", i, interrupt, pc_load, in_handler);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_timer();
      mie = 4'b1001; comp = 1'b1; instr_valid = 1'b1;
      tick();
      vectors++; if (interrupt !== 1'b1) begin miscompares++; $display("FAIL tmr_interrupt got %b exp 1", interrupt); end
      vectors++; if (pc_load !== 1'b1) begin miscompares++; $display("FAIL tmr_pc_load got %b exp 1", pc_load); end
      vectors++; if (new_pc !== 32'h0000_011C) begin miscompares++; $display("FAIL tmr_new_pc got %h exp 0000011c", new_pc); end
      vectors++; if (mcause !== 32'h8000_0007) begin miscompares++; $display("FAIL tmr_mcause got %h exp 80000007", mcause); end
      vectors++; if (in_handler !== 1'b1) begin miscompares++; $display("FAIL tmr_in_handler got %b exp 1", in_handler); end
      comp = 1'b0; instr_valid = 1'b0;
      tick();
      vectors++; if (interrupt !== 1'b0 || pc_load !== 1'b0) begin miscompares++; $display("FAIL tmr_pulse_width got int=%b pcl=%b exp 0/0", interrupt, pc_load); end
      mret = 1'b1; instr_valid = 1'b1; mepc = 32'h0000_0040;
      tick();
      vectors++; if (pc_load !== 1'b1) begin miscompares++; $display("FAIL ret_pc_load got %b exp 1", pc_load); end
      vectors++; if (new_pc !== 32'h0000_0040) begin miscompares++; $display("FAIL ret_new_pc got %h exp 00000040", new_pc); end
      vectors++; if (in_handler !== 1'b0) begin miscompares++; $display("FAIL ret_in_handler got %b exp 0", in_handler); end
      vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL ret_interrupt got %b exp 0", interrupt); end
      mret = 1'b0; instr_valid = 1'b0;
      tick();
      vectors++; if (pc_load !== 1'b0) begin miscompares++; $display("FAIL ret_pulse_width got %b exp 0", pc_load); end
      // mret in IDLE must not redirect
      mret = 1'b1; instr_valid = 1'b1; mepc = 32'h0000_0999;
      tick(); tick();
      vectors++; if (pc_load !== 1'b0) begin miscompares++; $display("FAIL idle_mret got pc_load=%b exp 0", pc_load); end
      mret = 1'b0; instr_valid = 1'b0;
      $display("test_timer done");
   endtask

   task automatic test_priority();
      mie = 4'h0; ext_irq = 1'b0;
      tick(); tick(); tick(); tick();
      ext_irq = 1'b1;
      tick(); tick(); tick(); tick();
      mie = 4'b1111; sw_irq = 1'b1; comp = 1'b1; ecall = 1'b1; instr_valid = 1'b1;
      tick();
      vectors++; if (mcause !== 32'h0000_000B) begin miscompares++; $display("FAIL prio_ecall_mcause got %h exp 0000000b", mcause); end
      vectors++; if (new_pc !== 32'h0000_012C) begin miscompares++; $display("FAIL prio_ecall_new_pc got %h exp 0000012c", new_pc); end
      ecall = 1'b0; instr_valid = 1'b0;
      tick();
      mret = 1'b1; instr_valid = 1'b1; mepc = 32'h0000_0200;
      tick();
      vectors++; if (pc_load !== 1'b1 || new_pc !== 32'h0000_0200) begin miscompares++; $display("FAIL prio_ret got pcl=%b pc=%h exp 1/00000200", pc_load, new_pc); end
      mret = 1'b0;
      tick();
      vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL prio_idle_gap got %b exp 0", interrupt); end
      tick();
      vectors++; if (mcause !== 32'h8000_000B) begin miscompares++; $display("FAIL prio_ext_mcause got %h exp 8000000b", mcause); end
      vectors++; if (new_pc !== 32'h0000_012C || interrupt !== 1'b1) begin miscompares++; $display("FAIL prio_ext_entry got pc=%h int=%b exp 0000012c/1", new_pc, interrupt); end
      sw_irq = 1'b0; comp = 1'b0; mie = 4'h0; instr_valid = 1'b0;
      tick();
      mret = 1'b1; instr_valid = 1'b1;
      tick();
      mret = 1'b0; instr_valid = 1'b0;
      tick(); tick();
      $display("test_priority done");
   endtask

   task automatic test_masking();
      mie = 4'b0111; ext_irq = 1'b0;
      tick(); tick(); tick(); tick();
      ext_irq = 1'b1; sw_irq = 1'b1; comp = 1'b1; instr_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL mask_global_off cyc %0d got %b exp 0", i, interrupt); end
      end
      mie = 4'b1111;
      tick();
      vectors++; if (interrupt !== 1'b1 || mcause !== 32'h8000_000B) begin miscompares++; $display("FAIL mask_enable got int=%b cause=%h exp 1/8000000b", interrupt, mcause); end
      sw_irq = 1'b0; comp = 1'b0; instr_valid = 1'b0;
      tick();
      $display("test_masking done");
   endtask

   task automatic test_no_nesting();
      comp = 1'b1; ecall = 1'b1; instr_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         vectors++; if (interrupt !== 1'b0 || pc_load !== 1'b0) begin miscompares++; $display("FAIL nest cyc %0d got int=%b pcl=%b exp 0/0", i, interrupt, pc_load); end
      end
      ecall = 1'b0; mret = 1'b1; mie = 4'b1001; mepc = 32'h0000_0480;
      tick();
      vectors++; if (pc_load !== 1'b1 || new_pc !== 32'h0000_0480 || in_handler !== 1'b0) begin miscompares++; $display("FAIL nest_ret got pcl=%b pc=%h inh=%b exp 1/00000480/0", pc_load, new_pc, in_handler); end
      mret = 1'b0;
      tick();
      vectors++; if (interrupt !== 1'b0 || pc_load !== 1'b0) begin miscompares++; $display("FAIL nest_idle_gap got int=%b pcl=%b exp 0/0", interrupt, pc_load); end
      tick();
      vectors++; if (interrupt !== 1'b1 || mcause !== 32'h8000_0007 || new_pc !== 32'h0000_011C) begin miscompares++; $display("FAIL nest_retake got int=%b cause=%h pc=%h exp 1/80000007/0000011c", interrupt, mcause, new_pc); end
      comp = 1'b0; instr_valid = 1'b0;
      tick();
      mret = 1'b1; instr_valid = 1'b1;
      tick();
      mret = 1'b0; instr_valid = 1'b0;
      tick(); tick();
      $display("test_no_nesting done");
   endtask

   task automatic test_reset_in_enter();
      mie = 4'h0; ext_irq = 1'b0;
      tick(); tick(); tick(); tick();
      ext_irq = 1'b1;
      tick(); tick(); tick(); tick();
      mie = 4'b1001; comp = 1'b1; instr_valid = 1'b1;
      tick();
      vectors++; if (interrupt !== 1'b1) begin miscompares++; $display("FAIL rie_enter got %b exp 1", interrupt); end
      #2;
      rst = 1'b0; ext_irq = 1'b0; comp = 1'b0; instr_valid = 1'b0;
      #1;
      vectors++; if (interrupt !== 1'b0 || pc_load !== 1'b0 || in_handler !== 1'b0) begin miscompares++; $display("FAIL rie_async got int=%b pcl=%b inh=%b exp 0/0/0", interrupt, pc_load, in_handler); end
      vectors++; if (new_pc !== 32'd0 || mcause !== 32'd0) begin miscompares++; $display("FAIL rie_async_regs got pc=%h cause=%h exp 0/0", new_pc, mcause); end
      tick();
      rst = 1'b1;
      mie = 4'b1100; instr_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         vectors++; if (interrupt !== 1'b0 || mcause !== 32'd0) begin miscompares++; $display("FAIL rie_pend_lost cyc %0d got int=%b cause=%h exp 0/0", i, interrupt, mcause); end
      end
      instr_valid = 1'b0; mie = 4'h0;
      $display("test_reset_in_enter done");
   endtask

   initial begin
      test_reset();
      test_timer();
      test_priority();
      test_masking();
      test_no_nesting();
      test_reset_in_enter();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
